// File: rtl/multicore_proc_core_if.sv
// Data-memory req/ack handshake between a multicore_proc_core (master)
// and the shared data-memory arbiter (slave).
interface multicore_proc_core_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned MEM_ADDR   = 12
);
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicore_proc_core.sv
// Multicycle accumulator core with general registers, LDCID and a req/ack data-memory port.
// Optional MUL (opcode Dr) is enabled by defining the macro MUL_EN.
module multicore_proc_core #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned INS_WIDTH  = 8,
  parameter int unsigned MEM_ADDR   = 12,
  parameter int unsigned INS_ADDR   = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned CORE_ID    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [INS_ADDR-1:0]  ins_addr,
  input  logic [INS_WIDTH-1:0] ins_data,
  multicore_proc_core_if.master mem,
  output logic                 z_flag,
  output logic                 ready,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_MEM_WAIT, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_SYS   = 4'h0, OP_LDAC = 4'h1, OP_STAC  = 4'h2, OP_MVAC  = 4'h3,
    OP_MOVR  = 4'h4, OP_ADD  = 4'h5, OP_SUB   = 4'h6, OP_INC   = 4'h7,
    OP_CLR   = 4'h8, OP_JPNZ = 4'h9, OP_JUMP  = 4'hA, OP_LDCID = 4'hB,
    OP_LDI   = 4'hC, OP_MUL  = 4'hD, OP_RSV_E = 4'hE, OP_RSV_F = 4'hF
  } op_e;

  state_e                state_q, state_d;
  logic [INS_ADDR-1:0]   pc_q, pc_d;
  logic [INS_WIDTH-1:0]  ir_q, ir_d;
  logic [INS_WIDTH-1:0]  opr_q, opr_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  z_q, z_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  op_e                   op;
  logic [3:0]            rsel;
  logic                  r_ok;
  logic [DATA_WIDTH-1:0] rval;
  logic                  legal;
  logic                  two_byte;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] reg_wval;
  logic [DATA_WIDTH-1:0] alu;

  assign op   = op_e'(ir_q[7:4]);
  assign rsel = ir_q[3:0];
  assign r_ok = (32'(rsel) < NUM_REGS);

  always_comb begin
    rval = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(rsel) == i) rval = regs_q[i];
    end
  end

  // Register-form ops are only legal when r names an implemented register.
  always_comb begin
    legal    = 1'b0;
    two_byte = 1'b0;
    case (op)
      OP_SYS:   legal = (ir_q[3:0] == 4'h0) || (ir_q[3:0] == 4'h1);
      OP_LDAC, OP_STAC, OP_MVAC, OP_MOVR,
      OP_ADD, OP_SUB, OP_INC, OP_CLR:
                legal = r_ok;
      OP_JPNZ, OP_JUMP: begin
        legal    = (ir_q[3:0] == 4'h0);
        two_byte = 1'b1;
      end
      OP_LDCID: legal = (ir_q[3:0] == 4'h0);
      OP_LDI: begin
        legal    = r_ok;
        two_byte = 1'b1;
      end
`ifdef MUL_EN
      OP_MUL:   legal = r_ok;
`endif
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    regs_d   = regs_q;
    z_d      = z_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    reg_we   = 1'b0;
    reg_wval = '0;
    alu      = '0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = ins_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else if (two_byte) begin
          state_d = S_OPERAND;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_OPERAND: begin
        opr_d   = ins_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_SYS: begin
            if (ir_q[0]) begin
              done_d  = 1'b1;
              state_d = S_HALT;
            end
          end
          OP_LDAC: begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = MEM_ADDR'(rval);
            wdata_d = '0;
            state_d = S_MEM_WAIT;
          end
          OP_STAC: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = MEM_ADDR'(rval);
            wdata_d = acc_q;
            state_d = S_MEM_WAIT;
          end
          OP_MVAC: begin
            reg_we   = 1'b1;
            reg_wval = acc_q;
          end
          OP_MOVR: acc_d = rval;
          OP_ADD: begin
            alu   = acc_q + rval;
            acc_d = alu;
            z_d   = (alu == '0);
          end
          OP_SUB: begin
            alu   = acc_q - rval;
            acc_d = alu;
            z_d   = (alu == '0);
          end
          OP_INC: begin
            reg_we   = 1'b1;
            reg_wval = rval + 1'b1;
          end
          OP_CLR: begin
            reg_we   = 1'b1;
            reg_wval = '0;
          end
          OP_JPNZ: begin
            if (!z_q) pc_d = INS_ADDR'(opr_q);
          end
          OP_JUMP:  pc_d  = INS_ADDR'(opr_q);
          OP_LDCID: acc_d = DATA_WIDTH'(CORE_ID);
          OP_LDI: begin
            reg_we   = 1'b1;
            reg_wval = DATA_WIDTH'(opr_q);
          end
`ifdef MUL_EN
          OP_MUL: begin
            alu   = acc_q * rval;
            acc_d = alu;
            z_d   = (alu == '0);
          end
`endif
          default: ;
        endcase
      end
      S_MEM_WAIT: begin
        // Request fields stay frozen in their flops until the ack cycle.
        if (mem.mem_ack) begin
          if (!we_q) acc_d = mem.mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reg_we && (32'(rsel) == i)) regs_d[i] = reg_wval;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      acc_q   <= '0;
      regs_q  <= '{default: '0};
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ins_addr      = pc_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign z_flag        = z_q;
  assign ready         = (state_q == S_IDLE);
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_multicore_proc_core.sv
// Scoreboard bench for multicore_proc_core: directed programs push expected
// memory transactions and halt results; monitors pop and compare.
module tb_multicore_proc_core;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ins_addr;
  logic [7:0]  ins_data;
  logic        z_flag, ready, done, error;

  multicore_proc_core_if #(.DATA_WIDTH(12), .MEM_ADDR(12)) mif ();

  multicore_proc_core #(
    .DATA_WIDTH(12), .INS_WIDTH(8), .MEM_ADDR(12),
    .INS_ADDR(8), .NUM_REGS(8), .CORE_ID(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ins_addr (ins_addr),
    .ins_data (ins_data),
    .mem      (mif),
    .z_flag   (z_flag),
    .ready    (ready),
    .done     (done),
    .error    (error)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
    int unsigned len;
  } txn_t;

  typedef struct {
    logic        done;
    logic        error;
    logic        z;
    int unsigned cycles;
  } halt_t;

  txn_t        exp_mem[$];
  halt_t       exp_halt[$];
  logic [7:0]  imem [0:255];
  logic [7:0]  prog [$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int unsigned mem_delay = 0;
  logic [11:0] rd_val = '0;

  assign ins_data = imem[ins_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_txn(input logic we, input logic [11:0] a, input logic [11:0] d,
                         input int unsigned len);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.len = len;
    exp_mem.push_back(t);
  endtask

  task automatic exp_end(input logic dn, input logic er, input logic z, input int unsigned cycles);
    halt_t h;
    h.done = dn; h.error = er; h.z = z; h.cycles = cycles;
    exp_halt.push_back(h);
  endtask

  task automatic load();
    for (int i = 0; i < 256; i++) imem[i] = 8'h02;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
  endtask

  task automatic run(input int unsigned dly, input logic [11:0] rd);
    mem_delay = dly;
    rd_val    = rd;
    load();
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    t_start = cyc;
    chk("start_pc", 32'(ins_addr), 32'h0);
    chk("start_ready", 32'(ready), 32'h0);
    for (int i = 0; i < 1000 && !(done || error); i++) @(negedge clock);
    chk("halt_reached", 32'(done || error), 32'h1);
    repeat (2) @(negedge clock);
  endtask

  // Arbiter model: acks after mem_delay wait cycles, drives just after the edge.
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mif.mem_req && !mif.mem_ack) begin
        if (wcnt == mem_delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rd_val;
        end else begin
          wcnt++;
        end
      end else begin
        mif.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: memory transactions and halt events.
  initial begin
    logic        in_txn, stable, h_prev;
    logic        c_we;
    logic [11:0] c_addr, c_wdata;
    int unsigned len;
    txn_t        e;
    halt_t       h;
    in_txn = 1'b0; stable = 1'b1; h_prev = 1'b0; len = 0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0;
    forever begin
      @(negedge clock);
      if (mif.mem_req) begin
        if (!in_txn) begin
          c_we = mif.mem_we; c_addr = mif.mem_addr; c_wdata = mif.mem_wdata;
          len = 0; stable = 1'b1; in_txn = 1'b1;
        end else if (mif.mem_we !== c_we || mif.mem_addr !== c_addr ||
                     mif.mem_wdata !== c_wdata) begin
          stable = 1'b0;
        end
        len++;
        if (mif.mem_ack) begin
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected actual=addr %0h we %0b expected=no transaction",
                     c_addr, c_we);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", 32'(c_we), 32'(e.we));
            chk("mem_addr", 32'(c_addr), 32'(e.addr));
            if (e.we) chk("mem_wdata", 32'(c_wdata), 32'(e.wdata));
            chk("mem_req_len", len, e.len);
            chk("mem_stable", 32'(stable), 32'h1);
          end
          in_txn = 1'b0;
        end
      end else begin
        in_txn = 1'b0;
      end
      if ((done || error) && !h_prev) begin
        if (exp_halt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL halt_unexpected actual=done %0b error %0b expected=no halt", done, error);
        end else begin
          h = exp_halt.pop_front();
          chk("halt_done", 32'(done), 32'(h.done));
          chk("halt_error", 32'(error), 32'(h.error));
          chk("halt_z", 32'(z_flag), 32'(h.z));
          chk("halt_cycles", cyc - t_start, h.cycles);
        end
      end
      h_prev = done || error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    prog  = {};
    load();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_pc", 32'(ins_addr), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_z", 32'(z_flag), 32'h0);
    chk("rst_req", 32'(mif.mem_req), 32'h0);
    chk("rst_we", 32'(mif.mem_we), 32'h0);
    @(negedge clock) reset = 1'b1;

    // Reset asserted mid-instruction once PC has advanced.
    prog = {8'hC7, 8'h01, 8'h27, 8'h01};
    load();
    @(negedge clock) start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 chk("pc_advance", 32'(ins_addr), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'h1);
    chk("midrst_pc", 32'(ins_addr), 32'h0);
    chk("midrst_req", 32'(mif.mem_req), 32'h0);
    @(negedge clock) reset = 1'b1;

    // ACC is zero after reset: store it.
    exp_txn(1'b1, 12'h001, 12'h000, 1);
    exp_end(1'b1, 1'b0, 1'b0, 11);
    run(0, 12'h000);

    // LDI/ADD: 5 + 7 = 0x00C.
    prog = {8'hC0, 8'h05, 8'hC1, 8'h07, 8'hC2, 8'h10, 8'h40, 8'h51, 8'h22, 8'h01};
    exp_txn(1'b1, 12'h010, 12'h00C, 1);
    exp_end(1'b1, 1'b0, 1'b0, 25);
    run(0, 12'h000);

    // Countdown loop, three iterations.
    prog = {8'hC0, 8'h03, 8'hC1, 8'h01, 8'h40, 8'h61, 8'h30, 8'h90, 8'h04,
            8'hC2, 8'h20, 8'h22, 8'h01};
    exp_txn(1'b1, 12'h020, 12'h000, 1);
    exp_end(1'b1, 1'b0, 1'b1, 58);
    run(0, 12'h000);

    // Handshake with 5 wait cycles: LDAC from 0x123, then two stores.
    prog = {8'hC0, 8'hFF, 8'hC1, 8'h24, 8'h40, 8'h51, 8'h32, 8'h12,
            8'hC3, 8'h40, 8'h23, 8'hC4, 8'h55, 8'h44, 8'h23, 8'h01};
    exp_txn(1'b0, 12'h123, 12'h000, 6);
    exp_txn(1'b1, 12'h040, 12'hABC, 6);
    exp_txn(1'b1, 12'h040, 12'h055, 6);
    exp_end(1'b1, 1'b0, 1'b0, 58);
    run(5, 12'hABC);

    // Illegal: register index beyond NUM_REGS, and a bad low nibble.
    prog = {8'h4F};
    exp_end(1'b0, 1'b1, 1'b0, 2);
    run(0, 12'h000);
    prog = {8'h91, 8'h00, 8'h01};
    exp_end(1'b0, 1'b1, 1'b0, 2);
    run(0, 12'h000);

    // LDCID with CORE_ID=3.
    prog = {8'hB0, 8'hC5, 8'h77, 8'h25, 8'h01};
    exp_txn(1'b1, 12'h077, 12'h003, 1);
    exp_end(1'b1, 1'b0, 1'b0, 14);
    run(0, 12'h000);

    // 0x800 * 2 overflows to zero when MUL exists; otherwise D0 is illegal.
    prog = {8'hC0, 8'h80, 8'h40, 8'h50, 8'h30, 8'h50, 8'h30, 8'h50, 8'h30, 8'h50,
            8'hC0, 8'h02, 8'hD0, 8'hC1, 8'h30, 8'h21, 8'h01};
`ifdef MUL_EN
    exp_txn(1'b1, 12'h030, 12'h000, 1);
    exp_end(1'b1, 1'b0, 1'b1, 46);
`else
    exp_end(1'b0, 1'b1, 1'b0, 34);
`endif
    run(0, 12'h000);

    // CLR/INC, SUB borrow wrap to 0xFFF, ADD carry wrap to 0, JUMP over an
    // illegal byte, JPNZ not taken with Z=1.
    prog = {8'h80, 8'h40, 8'h70, 8'h60, 8'hC2, 8'h50, 8'h22, 8'h50, 8'h22,
            8'hA0, 8'h0C, 8'h02, 8'h90, 8'h0B, 8'h01};
    exp_txn(1'b1, 12'h050, 12'hFFF, 1);
    exp_txn(1'b1, 12'h050, 12'h000, 1);
    exp_end(1'b1, 1'b0, 1'b1, 38);
    run(0, 12'h000);

    repeat (4) @(negedge clock);
    chk("mem_queue_drained", exp_mem.size(), 32'h0);
    chk("halt_queue_drained", exp_halt.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
